funct_generator_mc: RTL and testbench

Multi-channel, parametrised successor to the single-channel function generator. It holds an independent waveform configuration (shape, amplitude, phase step) per channel. It generates samples round-robin across channels through a 2-stage arithmetic pipeline and writes tagged samples into the downstream sample FIFO, stalling on FIFO-full without loss or duplication.

---
 rtl/funct_generator_mc.sv | 211 +++++++++++++++++++++
 tb/tb_funct_generator_mc.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/funct_generator_mc.sv
// Multi-channel function generator: per-channel waveform configuration, round-robin
// sample issue through a 2-stage multiply/saturate pipeline into a downstream FIFO.
module funct_generator_mc #(
  parameter  int CHANNELS   = 4,
  parameter  int LUT_ADDR   = 6,
  parameter  int INT_BITS   = 8,
  parameter  int DATA_WIDTH = 12,
  localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enh_conf_i,
  input  logic                         en_low_i,
  input  logic                         cfg_we_i,
  input  logic [CH_W-1:0]              cfg_ch_i,
  input  logic [1:0]                   cfg_sel_i,
  input  logic signed [INT_BITS-1:0]   cfg_amp_i,
  input  logic [LUT_ADDR-1:0]          cfg_step_i,
  input  logic                         fifo_full_i,
  output logic                         wr_en_o,
  output logic signed [DATA_WIDTH-1:0] data_o,
  output logic [CH_W-1:0]              ch_o,
  output logic [1:0]                   state_o
);

  localparam int P  = LUT_ADDR;
  localparam int PW = P + 1 + INT_BITS;
  localparam int EW = ((PW > DATA_WIDTH) ? PW : DATA_WIDTH) + 1;

  localparam logic signed [P+1:0]  W_H     = (P+2)'(2 ** (P - 1));
  localparam logic signed [P+1:0]  W_ONE   = (P+2)'(1);
  localparam logic signed [EW-1:0] SAT_MAX = EW'(2 ** (DATA_WIDTH - 1) - 1);
  localparam logic signed [EW-1:0] SAT_MIN = EW'(-(2 ** (DATA_WIDTH - 1)));
  localparam logic [CH_W:0]        CH_LIM  = (CH_W+1)'(CHANNELS);
  localparam logic [CH_W-1:0]      LAST_CH = CH_W'(CHANNELS - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONFIG = 2'd1,
    ST_GEN    = 2'd2
  } state_t;

  state_t state_r, state_nx_s;

  logic [1:0]                 sel_r   [CHANNELS];
  logic signed [INT_BITS-1:0] amp_r   [CHANNELS];
  logic [P-1:0]               step_r  [CHANNELS];
  logic [P-1:0]               phase_r [CHANNELS];
  logic [CH_W-1:0]            ptr_r;

  logic                       v1_r;
  logic signed [P:0]          w1_r;
  logic signed [INT_BITS-1:0] amp1_r;
  logic [CH_W-1:0]            ch1_r;

  logic                       v2_r;
  logic signed [DATA_WIDTH-1:0] data_r;
  logic [CH_W-1:0]            ch_r;

  logic                       issue_s;
  logic                       cfg_wr_s;
  logic signed [PW-1:0]       prod_s;

  // Waveform value for one channel, signed P+1 bits, centred on zero.
  function automatic logic signed [P:0] wave_f(input logic [1:0] sel, input logic [P-1:0] a);
    logic signed [P+1:0] ax;
    logic signed [P+1:0] res;
    ax  = $signed({2'b00, a});
    res = W_ONE;
    case (sel)
      2'd0:    res = a[P-1] ? (W_ONE - W_H) : (W_H - W_ONE);
      2'd1:    res = a[P-1] ? (W_H + W_H + W_H - W_ONE - ax - ax) : (ax + ax - W_H);
      2'd2:    res = ax - W_H;
      2'd3:    res = W_ONE;
      default: res = W_ONE;
    endcase
    return res[P:0];
  endfunction

  // Clamp the full-width product into the output sample range.
  function automatic logic signed [DATA_WIDTH-1:0] sat_f(input logic signed [PW-1:0] p);
    logic signed [EW-1:0] pe;
    pe = EW'(p);
    if (pe > SAT_MAX) begin
      return SAT_MAX[DATA_WIDTH-1:0];
    end else if (pe < SAT_MIN) begin
      return SAT_MIN[DATA_WIDTH-1:0];
    end else begin
      return pe[DATA_WIDTH-1:0];
    end
  endfunction

  assign issue_s  = (state_r == ST_GEN) && !fifo_full_i;
  assign cfg_wr_s = (state_r == ST_CONFIG) && cfg_we_i && ({1'b0, cfg_ch_i} < CH_LIM);
  assign prod_s   = PW'(w1_r) * PW'(amp1_r);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state decode; GEN exits on either config request or enable release.
  always_comb begin
    state_nx_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (enh_conf_i) begin
          state_nx_s = ST_CONFIG;
        end else if (!en_low_i) begin
          state_nx_s = ST_GEN;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_CONFIG: begin
        if (enh_conf_i) begin
          state_nx_s = ST_CONFIG;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_GEN: begin
        if (enh_conf_i || en_low_i) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_GEN;
        end
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Per-channel configuration and phase accumulators.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        sel_r[i]   <= 2'd0;
        amp_r[i]   <= '0;
        step_r[i]  <= P'(1);
        phase_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (cfg_wr_s && (cfg_ch_i == CH_W'(i))) begin
          sel_r[i]  <= cfg_sel_i;
          amp_r[i]  <= cfg_amp_i;
          step_r[i] <= cfg_step_i;
        end
        // Phases only run in GEN so every generate burst starts from zero.
        if (state_r != ST_GEN) begin
          phase_r[i] <= '0;
        end else if (issue_s && (ptr_r == CH_W'(i))) begin
          phase_r[i] <= phase_r[i] + step_r[i];
        end
      end
    end
  end

  // Round-robin channel pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r <= '0;
    end else if (state_r != ST_GEN) begin
      ptr_r <= '0;
    end else if (issue_s) begin
      ptr_r <= (ptr_r == LAST_CH) ? '0 : ptr_r + CH_W'(1);
    end
  end

  // Stage 1: waveform lookup; the whole pipeline freezes while the FIFO is full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_r   <= 1'b0;
      w1_r   <= '0;
      amp1_r <= '0;
      ch1_r  <= '0;
    end else if (!fifo_full_i) begin
      v1_r <= issue_s;
      if (issue_s) begin
        w1_r   <= wave_f(sel_r[ptr_r], phase_r[ptr_r]);
        amp1_r <= amp_r[ptr_r];
        ch1_r  <= ptr_r;
      end
    end
  end

  // Stage 2: scale, saturate and present the tagged sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2_r   <= 1'b0;
      data_r <= '0;
      ch_r   <= '0;
    end else if (!fifo_full_i) begin
      v2_r <= v1_r;
      if (v1_r) begin
        data_r <= sat_f(prod_s);
        ch_r   <= ch1_r;
      end
    end
  end

  assign wr_en_o = v2_r && !fifo_full_i;
  assign data_o  = data_r;
  assign ch_o    = ch_r;
  assign state_o = state_r;

endmodule

// File: tb/tb_funct_generator_mc.sv
// Randomised scoreboard bench for funct_generator_mc against a behavioural
// per-channel model; directed checks for sweep, saturation, gating and reset.
module tb_funct_generator_mc;

  localparam int CH = 4;
  localparam int P  = 6;
  localparam int IB = 8;
  localparam int DW = 12;
  localparam int CW = 2;
  localparam int H  = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic enh_conf = 1'b0;
  logic en_low = 1'b1;
  logic cfg_we = 1'b0;
  logic [CW-1:0] cfg_ch = '0;
  logic [1:0] cfg_sel = '0;
  logic signed [IB-1:0] cfg_amp = '0;
  logic [P-1:0] cfg_step = '0;
  logic fifo_full = 1'b0;
  logic wr_en;
  logic signed [DW-1:0] data_o;
  logic [CW-1:0] ch_o;
  logic [1:0] state_o;

  funct_generator_mc #(
    .CHANNELS(CH), .LUT_ADDR(P), .INT_BITS(IB), .DATA_WIDTH(DW)
  ) dut (
    .clk(clk), .rst(rst), .enh_conf_i(enh_conf), .en_low_i(en_low),
    .cfg_we_i(cfg_we), .cfg_ch_i(cfg_ch), .cfg_sel_i(cfg_sel),
    .cfg_amp_i(cfg_amp), .cfg_step_i(cfg_step), .fifo_full_i(fifo_full),
    .wr_en_o(wr_en), .data_o(data_o), .ch_o(ch_o), .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct { int ch; int val; int adv; } exp_t;
  typedef struct { int ch; int val; } obs_t;
  exp_t sb_q[$];
  obs_t got_q[$];
  int n_cmp = 0;
  int n_err = 0;

  int m_state, m_ptr;
  int m_sel[CH], m_amp[CH], m_step[CH], m_phase[CH];

  function automatic int ref_sample(int sel, int a, int amp);
    int w, p;
    case (sel)
      0: w = (a < H) ? H - 1 : -(H - 1);
      1: w = (a < H) ? 2 * a - H : 3 * H - 1 - 2 * a;
      2: w = a - H;
      default: w = 1;
    endcase
    p = w * amp;
    if (p > 2047) p = 2047;
    else if (p < -2048) p = -2048;
    return p;
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_ptr = 0;
    for (int i = 0; i < CH; i++) begin
      m_sel[i] = 0; m_amp[i] = 0; m_step[i] = 1; m_phase[i] = 0;
    end
    sb_q.delete();
  endtask

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: acts on the inputs seen at each rising edge.
  initial begin
    model_reset();
    forever begin
      int nxt;
      exp_t e;
      @(posedge clk or posedge rst);
      if (rst) begin
        model_reset();
      end else begin
        if (!fifo_full)
          foreach (sb_q[i]) sb_q[i].adv = sb_q[i].adv + 1;
        if (m_state == 2 && !fifo_full) begin
          e.ch = m_ptr;
          e.val = ref_sample(m_sel[m_ptr], m_phase[m_ptr], m_amp[m_ptr]);
          e.adv = 0;
          sb_q.push_back(e);
          m_phase[m_ptr] = (m_phase[m_ptr] + m_step[m_ptr]) % 64;
          m_ptr = (m_ptr + 1) % CH;
        end
        if (m_state == 1 && cfg_we && int'(cfg_ch) < CH) begin
          m_sel[cfg_ch] = int'(cfg_sel);
          m_amp[cfg_ch] = int'(cfg_amp);
          m_step[cfg_ch] = int'(cfg_step);
        end
        if (m_state != 2) begin
          m_ptr = 0;
          for (int i = 0; i < CH; i++) m_phase[i] = 0;
        end
        nxt = m_state;
        case (m_state)
          0: nxt = enh_conf ? 1 : (!en_low ? 2 : 0);
          1: nxt = enh_conf ? 1 : 0;
          default: nxt = (enh_conf || en_low) ? 0 : 2;
        endcase
        m_state = nxt;
      end
    end
  end

  // Monitor: checks write timing, state and every written sample.
  initial begin
    forever begin
      logic exp_wr;
      exp_t e;
      obs_t o;
      @(negedge clk);
      if (!rst) begin
        exp_wr = (sb_q.size() > 0) && (sb_q[0].adv >= 1) && !fifo_full;
        chk("wr_en", int'(wr_en), int'(exp_wr));
        chk("state", int'(state_o), m_state);
        if (wr_en && sb_q.size() > 0) begin
          e = sb_q.pop_front();
          chk("ch", int'(ch_o), e.ch);
          chk("data", int'(data_o), e.val);
          o.ch = int'(ch_o);
          o.val = int'(data_o);
          got_q.push_back(o);
        end
      end
    end
  end

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic cfg_wr(int c, int s, int a, int st, bit last);
    cfg_we = 1'b1;
    cfg_ch = CW'(c);
    cfg_sel = 2'(s);
    cfg_amp = IB'(a);
    cfg_step = P'(st);
    if (last) enh_conf = 1'b0;
    step(1);
    cfg_we = 1'b0;
  endtask

  task automatic enter_cfg();
    en_low = 1'b1;
    enh_conf = 1'b1;
    step(1);
  endtask

  task automatic stop_drain();
    en_low = 1'b1;
    fifo_full = 1'b0;
    cfg_we = 1'b0;
    step(5);
    chk("drained", sb_q.size(), 0);
  endtask

  task automatic chk_reset_outputs(string nm);
    chk({nm, "_wr"}, int'(wr_en), 0);
    chk({nm, "_data"}, int'(data_o), 0);
    chk({nm, "_ch"}, int'(ch_o), 0);
    chk({nm, "_state"}, int'(state_o), 0);
  endtask

  initial begin
    int c0[$];
    int c1[$];
    int hd, hc;

    // Reset asserted mid-cycle.
    #1 rst = 1'b1;
    #2 chk_reset_outputs("rst0");
    step(3);
    rst = 1'b0;
    step(3);
    chk("idle_after_rst", int'(state_o), 0);

    // Write attempt in IDLE must be ignored.
    cfg_we = 1'b1; cfg_ch = 2'd2; cfg_sel = 2'd2; cfg_amp = 8'sd90; cfg_step = 6'd3;
    step(1);
    cfg_we = 1'b0;

    // Sawtooth sweep on ch0; last write coincides with leaving CONFIG.
    enter_cfg();
    cfg_wr(0, 2, 1, 1, 1'b1);
    got_q.delete();
    en_low = 1'b0;
    step(2);
    cfg_we = 1'b1; cfg_ch = 2'd1; cfg_sel = 2'd2; cfg_amp = 8'sd100; cfg_step = 6'd5;
    step(1);
    cfg_we = 1'b0;
    step(4 * 66);
    stop_drain();
    chk("saw_first_n", int'(got_q.size() >= 5), 1);
    if (got_q.size() >= 5) begin
      chk("saw_w0_ch", got_q[0].ch, 0); chk("saw_w0", got_q[0].val, -32);
      chk("saw_w1_ch", got_q[1].ch, 1); chk("saw_w1", got_q[1].val, 0);
      chk("saw_w2", got_q[2].val, 0);
      chk("saw_w3_ch", got_q[3].ch, 3); chk("saw_w3", got_q[3].val, 0);
      chk("saw_w4_ch", got_q[4].ch, 0); chk("saw_w4", got_q[4].val, -31);
    end
    foreach (got_q[i]) if (got_q[i].ch == 0) c0.push_back(got_q[i].val);
    chk("saw_n", int'(c0.size() >= 65), 1);
    if (c0.size() >= 65) begin
      chk("saw_64th", c0[63], 31);
      chk("saw_wrap", c0[64], -32);
    end

    // Saturation low.
    enter_cfg();
    cfg_wr(0, 2, 127, 1, 1'b1);
    got_q.delete();
    en_low = 1'b0;
    step(6);
    stop_drain();
    chk("sat_lo_n", int'(got_q.size() > 0), 1);
    if (got_q.size() > 0) chk("sat_lo", got_q[0].val, -2048);

    // Saturation high and triangle; restart from ch0 phase 0.
    enter_cfg();
    cfg_wr(0, 2, -128, 1, 1'b0);
    cfg_wr(1, 1, 2, 16, 1'b1);
    got_q.delete();
    en_low = 1'b0;
    step(24);
    stop_drain();
    chk("sat_hi_n", int'(got_q.size() > 0), 1);
    if (got_q.size() > 0) begin
      chk("restart_ch", got_q[0].ch, 0);
      chk("sat_hi", got_q[0].val, 2047);
    end
    foreach (got_q[i]) if (got_q[i].ch == 1) c1.push_back(got_q[i].val);
    chk("tri_n", int'(c1.size() >= 5), 1);
    if (c1.size() >= 5) begin
      chk("tri_a0", c1[0], -64);
      chk("tri_a16", c1[1], 0);
      chk("tri_a32", c1[2], 62);
      chk("tri_a48", c1[3], -2);
      chk("tri_wrap", c1[4], -64);
    end

    // Randomised runs with backpressure, exits and write noise.
    for (int it = 0; it < 5; it++) begin
      enter_cfg();
      for (int c = 0; c < CH; c++) begin
        int st;
        st = $urandom_range(0, 63);
        if (it == 0 && c == 2) st = 0;
        if (it == 0 && c == 3) st = 63;
        cfg_wr(c, $urandom_range(0, 3), $urandom_range(0, 255) - 128, st, c == CH - 1);
      end
      en_low = 1'b0;
      for (int cyc = 0; cyc < 150; cyc++) begin
        fifo_full = ($urandom_range(0, 3) == 0);
        cfg_we = ($urandom_range(0, 9) == 0);
        cfg_ch = CW'($urandom);
        cfg_sel = 2'($urandom);
        cfg_amp = IB'($urandom);
        cfg_step = P'($urandom);
        if (cyc == 60) begin
          fifo_full = 1'b1;
          cfg_we = 1'b0;
          step(1);
          hd = int'(data_o);
          hc = int'(ch_o);
          repeat (4) begin
            step(1);
            chk("hold_wr", int'(wr_en), 0);
            chk("hold_data", int'(data_o), hd);
            chk("hold_ch", int'(ch_o), hc);
          end
          fifo_full = 1'b0;
        end
        if (cyc == 100) begin
          en_low = 1'b1;
          fifo_full = 1'b1;
          step(3);
          fifo_full = 1'b0;
          step(3);
          en_low = 1'b0;
        end
        if (it == 2 && cyc == 120) begin
          enh_conf = 1'b1;
          step(2);
          enh_conf = 1'b0;
        end
        step(1);
      end
      stop_drain();
    end

    // Reset while both pipeline stages hold samples.
    enter_cfg();
    cfg_wr(0, 2, 50, 3, 1'b1);
    en_low = 1'b0;
    step(10);
    @(posedge clk);
    #3 rst = 1'b1;
    #1 chk_reset_outputs("rst_gen");
    step(2);
    rst = 1'b0;
    got_q.delete();
    step(12);
    stop_drain();
    chk("rst_gen_n", int'(got_q.size() > 0), 1);
    foreach (got_q[i]) chk("rst_default_zero", got_q[i].val, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
